// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that bridges each transfer into an APB SETUP/ACCESS
// cycle against an internal word-wide register file.
module ahb_apb_bridge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              HCLK,
  input  logic              RESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              hready_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_xfer;
  logic              accept;
  logic              psel;
  logic              penable;
  logic              pready;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] prdata;
  logic              apb_done;
  logic              mem_we;
  logic              mem_rd;

  // SEQ is handled exactly like NONSEQ; IDLE/BUSY never start a transfer
  assign is_xfer  = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign accept   = (state == S_IDLE) && HSEL && is_xfer;

  assign psel     = (state != S_IDLE);
  assign penable  = (state == S_ACCESS);
  assign pready   = 1'b1;
  assign pwrite   = wr_q;
  assign paddr    = addr_q;
  assign prdata   = mem[paddr];
  assign apb_done = psel && penable && pready;
  assign mem_we   = apb_done && pwrite;
  assign mem_rd   = apb_done && !pwrite;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (accept) state_n = S_SETUP;
      S_SETUP:  state_n = S_ACCESS;
      S_ACCESS: if (pready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= S_IDLE;
      hready_q <= 1'b1;
      hrdata_q <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state    <= state_n;
      hready_q <= (state_n == S_IDLE);
      if (accept) begin
        addr_q <= HADDR;
        wr_q   <= HWRITE;
      end
      // first data-phase edge: master is now driving HWDATA
      if (state == S_SETUP) pwdata_q <= HWDATA;
      if (mem_rd) hrdata_q <= prdata;
    end
  end

  // Storage is not reset; async reset drops state so mem_we deasserts at once
  always_ff @(posedge HCLK) begin
    if (mem_we) mem[paddr] <= pwdata_q;
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hready_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        RESETn;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  int checks = 0;
  int errors = 0;

  ahb_apb_bridge #(
    .ADDR_W(8),
    .DATA_W(32),
    .DEPTH (256)
  ) dut (
    .HCLK     (HCLK),
    .RESETn   (RESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HWRITE   (HWRITE),
    .HTRANS   (HTRANS),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 8'h00;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!HREADYOUT && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (!HREADYOUT) begin
      errors++;
      $display("FAIL wait_ready: HREADYOUT=%b after %0d cycles, need 1", HREADYOUT, n);
    end
  endtask

  // Full transfer; returns at accept+2 edges +1ns with HREADYOUT expected high.
  task automatic xfer(input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [1:0] tr);
    wait_ready();
    HSEL   = 1'b1;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = a;
    tick(1);
    bus_idle();
    HWDATA = d;
    tick(2);
  endtask

  task automatic wr32(input logic [7:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 2'b10);
  endtask

  task automatic rd32(input logic [7:0] a);
    xfer(1'b0, a, 32'h0, 2'b10);
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    bus_idle();
    HWDATA = 32'h0;
    tick(4);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL reset_hready_in: got %b need 1", HREADYOUT);
    end
    RESETn = 1'b1;
    tick(1);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL reset_hready: got %b need 1", HREADYOUT);
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_hrdata: got %h need 00000000", HRDATA);
    end
  endtask

  task automatic test_single();
    wait_ready();
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 8'h24;
    tick(1);
    bus_idle();
    HWDATA = 32'hDEADBEEF;
    checks++;
    if (HREADYOUT !== 1'b0) begin
      errors++;
      $display("FAIL single_a0: HREADYOUT got %b need 0", HREADYOUT);
    end
    tick(1);
    checks++;
    if (HREADYOUT !== 1'b0) begin
      errors++;
      $display("FAIL single_a1: HREADYOUT got %b need 0", HREADYOUT);
    end
    tick(1);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL single_a2: HREADYOUT got %b need 1", HREADYOUT);
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL single_wr_hrdata: got %h need 00000000", HRDATA);
    end
    rd32(8'h24);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rd: got %h need deadbeef", HRDATA);
    end
    tick(5);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_hold: got %h need deadbeef", HRDATA);
    end
    wr32(8'h30, 32'h12345678);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_hold_wr: got %h need deadbeef", HRDATA);
    end
  endtask

  task automatic test_multi();
    logic [7:0]  ta [10];
    logic [31:0] td [10];
    logic [31:0] exp_d;
    ta = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h37,
           8'h80, 8'h42, 8'hA5, 8'h01, 8'h7E};
    td = '{32'hA1A1A1A1, 32'h00000080, 32'hFFFFFFFF, 32'h0000C0DE, 32'h37373737,
           32'h8080BEEF, 32'h42424242, 32'h5A5AA5A5, 32'h01010101, 32'h7E7E7E7E};
    for (int i = 0; i < 10; i++) wr32(ta[i], td[i]);
    tick(60);
    for (int i = 0; i < 10; i++) begin
      exp_d = td[i];
      for (int j = 0; j < 10; j++)
        if (ta[j] == ta[i]) exp_d = td[j];
      rd32(ta[i]);
      checks++;
      if (HRDATA !== exp_d) begin
        errors++;
        $display("FAIL multi_rd[%0d] addr %h: got %h need %h", i, ta[i], HRDATA, exp_d);
      end
    end
  endtask

  task automatic test_busy_ignore();
    wr32(8'h10, 32'hCAFE0010);
    wait_ready();
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 8'h20;
    tick(1);
    HADDR  = 8'h10;
    HWDATA = 32'h20202020;
    tick(2);
    bus_idle();
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL busy_end: HREADYOUT got %b need 1", HREADYOUT);
    end
    HWDATA = 32'hBADBAD10;
    tick(1);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL busy_no_queue: HREADYOUT got %b need 1", HREADYOUT);
    end
    rd32(8'h10);
    checks++;
    if (HRDATA !== 32'hCAFE0010) begin
      errors++;
      $display("FAIL busy_mem10: got %h need cafe0010", HRDATA);
    end
    rd32(8'h20);
    checks++;
    if (HRDATA !== 32'h20202020) begin
      errors++;
      $display("FAIL busy_mem20: got %h need 20202020", HRDATA);
    end
  endtask

  task automatic test_non_xfer();
    logic        sel [3];
    logic [1:0]  tr  [3];
    sel = '{1'b1, 1'b1, 1'b0};
    tr  = '{2'b00, 2'b01, 2'b10};
    for (int k = 0; k < 3; k++) begin
      HSEL   = sel[k];
      HTRANS = tr[k];
      HWRITE = 1'b1;
      HADDR  = 8'h24;
      tick(1);
      HWDATA = 32'h0BAD0BAD;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (HREADYOUT !== 1'b1) begin
          errors++;
          $display("FAIL nonxfer[%0d] c%0d: HREADYOUT got %b need 1", k, c, HREADYOUT);
        end
        tick(1);
      end
      bus_idle();
    end
    rd32(8'h24);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL nonxfer_mem24: got %h need deadbeef", HRDATA);
    end
    HSEL   = 1'b1;
    HTRANS = 2'b11;
    HWRITE = 1'b1;
    HADDR  = 8'h66;
    tick(1);
    bus_idle();
    HWDATA = 32'h66665EC0;
    checks++;
    if (HREADYOUT !== 1'b0) begin
      errors++;
      $display("FAIL seq_accept: HREADYOUT got %b need 0", HREADYOUT);
    end
    tick(2);
    rd32(8'h66);
    checks++;
    if (HRDATA !== 32'h66665EC0) begin
      errors++;
      $display("FAIL seq_mem66: got %h need 66665ec0", HRDATA);
    end
  endtask

  task automatic test_back_to_back();
    wr32(8'hB0, 32'hB0B0B0B0);
    wr32(8'hB1, 32'hB1B1B1B1);
    rd32(8'hB0);
    checks++;
    if (HRDATA !== 32'hB0B0B0B0) begin
      errors++;
      $display("FAIL b2b_b0: got %h need b0b0b0b0", HRDATA);
    end
    rd32(8'hB1);
    checks++;
    if (HRDATA !== 32'hB1B1B1B1) begin
      errors++;
      $display("FAIL b2b_b1: got %h need b1b1b1b1", HRDATA);
    end
  endtask

  task automatic test_reset_mid();
    wr32(8'h55, 32'h11111111);
    rd32(8'h55);
    checks++;
    if (HRDATA !== 32'h11111111) begin
      errors++;
      $display("FAIL rmid_pre: got %h need 11111111", HRDATA);
    end
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 8'h55;
    tick(1);
    bus_idle();
    HWDATA = 32'h99999999;
    tick(1);
    #2;
    RESETn = 1'b0;
    #1;
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL rmid_hready: got %b need 1", HREADYOUT);
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rmid_hrdata: got %h need 00000000", HRDATA);
    end
    tick(2);
    RESETn = 1'b1;
    tick(1);
    rd32(8'h55);
    checks++;
    if (HRDATA !== 32'h11111111) begin
      errors++;
      $display("FAIL rmid_mem55: got %h need 11111111", HRDATA);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_busy_ignore();
    test_non_xfer();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
